// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encodings and constants for the 1011 detector
package seq_det_pkg;
  localparam int STATE_W = 3;
  localparam int PATTERN_LEN = 4;
  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear beats increment)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/seq1011_detector.sv
// seq1011_detector: registered 1011 pattern FSM with selectable overlap and match counter
module seq1011_detector
  import seq_det_pkg::*;
#(
  parameter int MATCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               overlap_en,
  input  logic               count_clr,
  output logic               match,
  output logic [MATCH_W-1:0] match_count,
  output logic [STATE_W-1:0] state_out
);
  state_t state;
  logic hit;
  // S4 is only reachable from S3 on a valid 1
  assign hit = din_valid && din && state == S3;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S0;
      match <= 1'b0;
    end else begin
      match <= hit;
      case (state)
        S0: state <= din_valid && din ? S1 : S0;
        S1: state <= !din_valid ? S1 : din ? S1 : S2;
        S2: state <= !din_valid ? S2 : din ? S3 : S0;
        S3: state <= !din_valid ? S3 : din ? S4 : S2;
        S4: state <= !din_valid ? S4 : din ? S1 : overlap_en ? S2 : S0;
        default: state <= S0;
      endcase
    end
  assign state_out = state;
  sat_counter #(.W(MATCH_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(count_clr),
    .inc(hit),
    .q(match_count)
  );
endmodule

// File: tb/tb_seq1011_detector.sv
// tb_seq1011_detector: directed-vector bench for seq1011_detector (MATCH_W=2)
module tb_seq1011_detector;
  logic clk = 1'b0;
  logic rst, din, din_valid, overlap_en, count_clr;
  logic match;
  logic [1:0] match_count;
  logic [2:0] state_out;
  int n = 0;
  int err = 0;

  seq1011_detector #(.MATCH_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .overlap_en(overlap_en),
    .count_clr(count_clr),
    .match(match),
    .match_count(match_count),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic v, input logic d, input logic c);
    rst = r;
    din_valid = v;
    din = d;
    count_clr = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pack(input int m, input int c, input int s);
    return {1'(m), 2'(c), 3'(s)};
  endfunction

  task automatic test_reset;
    logic [5:0] e;
    for (int i = 0; i < 3; i++) begin
      tick(i < 2, i < 2, i < 2, 1'b0);
      e = pack(0, 0, 0);
      n++;
      if ({match, match_count, state_out} !== e) begin
        err++;
        $display("FAIL reset[%0d] got %b want %b", i, {match, match_count, state_out}, e);
      end
    end
  endtask

  task automatic test_basic;
    int b[5] = '{1, 0, 1, 1, 0};
    int v[5] = '{1, 1, 1, 1, 0};
    int m[5] = '{0, 0, 0, 1, 0};
    int c[5] = '{0, 0, 0, 1, 1};
    int s[5] = '{1, 2, 3, 4, 4};
    logic [5:0] e;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    overlap_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'(v[i]), 1'(b[i]), 1'b0);
      e = pack(m[i], c[i], s[i]);
      n++;
      if ({match, match_count, state_out} !== e) begin
        err++;
        $display("FAIL basic[%0d] got %b want %b", i, {match, match_count, state_out}, e);
      end
    end
  endtask

  task automatic test_overlap(input logic ov);
    int b[7] = '{1, 0, 1, 1, 0, 1, 1};
    int m1[7] = '{0, 0, 0, 1, 0, 0, 1};
    int c1[7] = '{0, 0, 0, 1, 1, 1, 2};
    int s1[7] = '{1, 2, 3, 4, 2, 3, 4};
    int m0[7] = '{0, 0, 0, 1, 0, 0, 0};
    int c0[7] = '{0, 0, 0, 1, 1, 1, 1};
    int s0[7] = '{1, 2, 3, 4, 0, 1, 1};
    logic [5:0] e;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    overlap_en = ov;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, 1'(b[i]), 1'b0);
      e = ov ? pack(m1[i], c1[i], s1[i]) : pack(m0[i], c0[i], s0[i]);
      n++;
      if ({match, match_count, state_out} !== e) begin
        err++;
        $display("FAIL overlap%0d[%0d] got %b want %b", ov, i, {match, match_count, state_out}, e);
      end
    end
  endtask

  task automatic test_gaps;
    int b[4] = '{1, 0, 1, 1};
    logic [5:0] e;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    overlap_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'(b[i]), 1'b0);
      e = pack(i == 3, i == 3, i + 1);
      n++;
      if ({match, match_count, state_out} !== e) begin
        err++;
        $display("FAIL gap_bit[%0d] got %b want %b", i, {match, match_count, state_out}, e);
      end
      for (int g = 0; g < 3; g++) begin
        tick(1'b0, 1'b0, 1'(~b[i]), 1'b0);
        e = pack(0, i == 3, i + 1);
        n++;
        if ({match, match_count, state_out} !== e) begin
          err++;
          $display("FAIL gap_hold[%0d.%0d] got %b want %b", i, g, {match, match_count, state_out}, e);
        end
      end
    end
  endtask

  task automatic test_saturation;
    int b[16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    int c[16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    int s[16] = '{1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 2, 3, 4, 2, 3, 4};
    logic [5:0] e;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    overlap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 1'(b[i]), 1'b0);
      e = pack(s[i] == 4, c[i], s[i]);
      n++;
      if ({match, match_count, state_out} !== e) begin
        err++;
        $display("FAIL sat[%0d] got %b want %b", i, {match, match_count, state_out}, e);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    e = pack(0, 3, 3);
    n++;
    if ({match, match_count, state_out} !== e) begin
      err++;
      $display("FAIL sat_pre_clr got %b want %b", {match, match_count, state_out}, e);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    e = pack(1, 0, 4);
    n++;
    if ({match, match_count, state_out} !== e) begin
      err++;
      $display("FAIL clr_vs_match got %b want %b", {match, match_count, state_out}, e);
    end
  endtask

  task automatic test_reset_mid;
    int b[3] = '{1, 0, 1};
    logic [5:0] e;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    overlap_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'(b[i]), 1'b0);
      e = pack(0, 0, i + 1);
      n++;
      if ({match, match_count, state_out} !== e) begin
        err++;
        $display("FAIL rst_mid_bit[%0d] got %b want %b", i, {match, match_count, state_out}, e);
      end
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    e = pack(0, 0, 0);
    n++;
    if ({match, match_count, state_out} !== e) begin
      err++;
      $display("FAIL rst_mid got %b want %b", {match, match_count, state_out}, e);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n++;
    if ({match, match_count, state_out} !== e) begin
      err++;
      $display("FAIL rst_mid_after got %b want %b", {match, match_count, state_out}, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    din_valid = 1'b0;
    overlap_en = 1'b1;
    count_clr = 1'b0;
    test_reset;
    test_basic;
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gaps;
    test_saturation;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
